ahb_cfg_master: RTL

// - AHB bus master that delivers one edge-detector job setup to the config slave at SLAVEADDRESS.
// - Writes five 32-bit words in fixed order: width, height, readStartAddress, writeStartAddress, filterType.
// - filterType is zero-extended to BUSWIDTH.
// - Sits on the host/test side of the AHB bus, opposite the config slave; runs one job per start pulse.

---
 rtl/ahb_pkg.sv | 16 +
 rtl/ahb_cfg_master.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_pkg.sv
// AHB encodings shared by the config master and the config slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/ahb_cfg_master.sv
// AHB master that writes one edge-detector job (five words) to the config slave.
// Build option CFG_RETRY_EN: reissue a word after an ERROR response, up to MAX_RETRY times.
//
// state  | meaning
// S_IDLE | waiting for start; job inputs latched on start
// S_REQ  | requesting/locking the bus; first (or retried) address phase issued on grant
// S_XFER | pipelined single writes of words idx..4
// S_DONE | one-cycle done pulse
// S_ERR  | one-cycle error pulse
module ahb_cfg_master
  import ahb_pkg::*;
#(
  parameter int unsigned BUSWIDTH     = 32,
  parameter int unsigned SLAVEADDRESS = 3337,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [BUSWIDTH-1:0] cfg_width,
  input  logic [BUSWIDTH-1:0] cfg_height,
  input  logic [BUSWIDTH-1:0] cfg_rd_addr,
  input  logic [BUSWIDTH-1:0] cfg_wr_addr,
  input  logic                cfg_filter,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                ahb_hbusreq,
  output logic                ahb_hlock,
  input  logic                ahb_hgrant,
  output logic [1:0]          ahb_htrans,
  output logic [2:0]          ahb_hburst,
  output logic [2:0]          ahb_hsize,
  output logic                ahb_hwrite,
  output logic [BUSWIDTH-1:0] ahb_haddr,
  output logic [BUSWIDTH-1:0] ahb_hwdata,
  input  logic                ahb_hready,
  input  logic                ahb_hresp
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {W_WIDTH, W_HEIGHT, W_RD_ADDR, W_WR_ADDR, W_FILTER} cfg_word_t;

`ifdef CFG_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam logic [3:0]          RETRY_LIMIT = RETRY_EN ? 4'(MAX_RETRY) : 4'd0;
  localparam logic [BUSWIDTH-1:0] SLAVE_ADDR  = BUSWIDTH'(SLAVEADDRESS);
  localparam logic [2:0]          LAST_WORD   = 3'(W_FILTER);

  state_t              state;
  htrans_t             htrans;
  logic [BUSWIDTH-1:0] width_q, height_q, rd_addr_q, wr_addr_q;
  logic                filter_q;
  logic [2:0]          idx;
  logic [2:0]          data_idx;
  logic                data_vld;
  logic [3:0]          retry_cnt;
  logic [2:0]          issue_idx;
  logic [BUSWIDTH-1:0] word_data;

  assign ahb_htrans = htrans;
  assign ahb_hburst = HBURST_SINGLE;
  assign ahb_hsize  = HSIZE_WORD;

  // word that the next address phase will carry once it is accepted
  assign issue_idx = (htrans == HTRANS_NONSEQ) ? idx + 3'd1 : idx;

  always_comb begin
    word_data = '0;
    case (cfg_word_t'(idx))
      W_WIDTH:   word_data = width_q;
      W_HEIGHT:  word_data = height_q;
      W_RD_ADDR: word_data = rd_addr_q;
      W_WR_ADDR: word_data = wr_addr_q;
      W_FILTER:  word_data = {{(BUSWIDTH-1){1'b0}}, filter_q};
      default:   word_data = '0;
    endcase
  end

  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      htrans      <= HTRANS_IDLE;
      ahb_haddr   <= '0;
      ahb_hwdata  <= '0;
      ahb_hwrite  <= 1'b0;
      ahb_hbusreq <= 1'b0;
      ahb_hlock   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      width_q     <= '0;
      height_q    <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      filter_q    <= 1'b0;
      idx         <= '0;
      data_idx    <= '0;
      data_vld    <= 1'b0;
      retry_cnt   <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            width_q     <= cfg_width;
            height_q    <= cfg_height;
            rd_addr_q   <= cfg_rd_addr;
            wr_addr_q   <= cfg_wr_addr;
            filter_q    <= cfg_filter;
            idx         <= '0;
            retry_cnt   <= '0;
            busy        <= 1'b1;
            ahb_hbusreq <= 1'b1;
            ahb_hlock   <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (ahb_hgrant && ahb_hready) begin
            htrans     <= HTRANS_NONSEQ;
            ahb_haddr  <= SLAVE_ADDR;
            ahb_hwrite <= 1'b1;
            state      <= S_XFER;
          end
        end
        S_XFER: begin
          if (data_vld && ahb_hresp == HRESP_ERROR) begin
            if (!ahb_hready) begin
              // first ERROR cycle: cancel the pipelined address, rewind to the failed word
              htrans <= HTRANS_IDLE;
              idx    <= data_idx;
            end else begin
              data_vld <= 1'b0;
              if (retry_cnt < RETRY_LIMIT) begin
                retry_cnt   <= retry_cnt + 4'd1;
                ahb_hbusreq <= 1'b1;
                state       <= S_REQ;
              end else begin
                error       <= 1'b1;
                busy        <= 1'b0;
                ahb_hlock   <= 1'b0;
                ahb_hbusreq <= 1'b0;
                ahb_hwrite  <= 1'b0;
                state       <= S_ERR;
              end
            end
          end else if (ahb_hready) begin
            if (data_vld)
              retry_cnt <= '0;
            if (data_vld && data_idx == LAST_WORD) begin
              data_vld    <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              ahb_hlock   <= 1'b0;
              ahb_hbusreq <= 1'b0;
              ahb_hwrite  <= 1'b0;
              state       <= S_DONE;
            end else begin
              data_vld <= (htrans == HTRANS_NONSEQ);
              if (htrans == HTRANS_NONSEQ) begin
                data_idx   <= idx;
                ahb_hwdata <= word_data;
                idx        <= idx + 3'd1;
              end
              if (issue_idx <= LAST_WORD && ahb_hgrant)
                htrans <= HTRANS_NONSEQ;
              else
                htrans <= HTRANS_IDLE;
              if (issue_idx > LAST_WORD)
                ahb_hbusreq <= 1'b0;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
